// File: rtl/ext_sram_arbiter_if.sv
// Requester and SRAM bus bundle for ext_sram_arbiter. The master modport is the
// arbiter's view (it masters the SRAM bus); slave is the requester/SRAM side.
interface ext_sram_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 26,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ack;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic [AW-1:0]      mem_waddr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_wvalid;
  logic               mem_wready;
  logic [AW-1:0]      mem_raddr;
  logic               mem_rvalid;
  logic               mem_rready;
  logic [DW-1:0]      mem_rdata;

  modport master (
    input  req, req_we, req_addr, req_wdata,
    output req_ack, rsp_rdata, rsp_err,
    output mem_waddr, mem_wdata, mem_wvalid, mem_raddr, mem_rvalid,
    input  mem_wready, mem_rready, mem_rdata
  );

  modport slave (
    output req, req_we, req_addr, req_wdata,
    input  req_ack, rsp_rdata, rsp_err,
    input  mem_waddr, mem_wdata, mem_wvalid, mem_raddr, mem_rvalid,
    output mem_wready, mem_rready, mem_rdata
  );
endinterface

// File: rtl/ext_sram_arbiter.sv
// Round-robin arbiter sharing one external SRAM among NREQ requesters, one
// transaction outstanding. Define EXT_SRAM_ARB_TIMEOUT_EN to abort stalled BUSY after TIMEOUT cycles.
module ext_sram_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned AW      = 26,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 1023
) (
  input logic            clk,
  input logic            rst_n,
  ext_sram_arbiter_if.master bus
);
  localparam int unsigned IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_nreq_check
    $error("ext_sram_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("ext_sram_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t          state;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   gnt_id;
  logic            we_q;
  logic            any_req;
  logic [IW-1:0]   sel_id;
  logic [IW-1:0]   scan;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_ready;

`ifdef EXT_SRAM_ARB_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  logic [TW-1:0] tmo_cnt;
`endif

  // First requester at or after last_grant+1, wrapping; last_grant itself is checked last.
  always_comb begin
    any_req = 1'b0;
    sel_id  = '0;
    scan    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan = IW'((32'(last_grant) + k) % NREQ);
      if (!any_req && bus.req[scan]) begin
        any_req = 1'b1;
        sel_id  = scan;
      end
    end
  end

  assign sel_we    = bus.req_we[sel_id];
  assign sel_addr  = bus.req_addr[sel_id*AW +: AW];
  assign sel_wdata = bus.req_wdata[sel_id*DW +: DW];
  assign sel_ready = we_q ? bus.mem_wready : bus.mem_rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= IW'(NREQ - 1);
      gnt_id         <= '0;
      we_q           <= 1'b0;
      bus.req_ack    <= '0;
      bus.rsp_rdata  <= '0;
      bus.rsp_err    <= 1'b0;
      bus.mem_waddr  <= '0;
      bus.mem_wdata  <= '0;
      bus.mem_wvalid <= 1'b0;
      bus.mem_raddr  <= '0;
      bus.mem_rvalid <= 1'b0;
`ifdef EXT_SRAM_ARB_TIMEOUT_EN
      tmo_cnt        <= '0;
`endif
    end else begin
      bus.req_ack <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id     <= sel_id;
            last_grant <= sel_id;
            we_q       <= sel_we;
            if (sel_we) begin
              bus.mem_wvalid <= 1'b1;
              bus.mem_waddr  <= sel_addr;
              bus.mem_wdata  <= sel_wdata;
            end else begin
              bus.mem_rvalid <= 1'b1;
              bus.mem_raddr  <= sel_addr;
            end
`ifdef EXT_SRAM_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            state <= BUSY;
          end
        end
        BUSY: begin
          // Ready has priority over a timeout expiring on the same edge.
          if (sel_ready) begin
            bus.mem_wvalid <= 1'b0;
            bus.mem_rvalid <= 1'b0;
            if (!we_q) bus.rsp_rdata <= bus.mem_rdata;
            bus.rsp_err         <= 1'b0;
            bus.req_ack[gnt_id] <= 1'b1;
            state               <= ACK;
          end
`ifdef EXT_SRAM_ARB_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            bus.mem_wvalid      <= 1'b0;
            bus.mem_rvalid      <= 1'b0;
            bus.rsp_rdata       <= '0;
            bus.rsp_err         <= 1'b1;
            bus.req_ack[gnt_id] <= 1'b1;
            state               <= ACK;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
